// File: rtl/spi_config_pkg.sv
// Shared opcodes and FSM encoding for the SPI configuration port.
// Pure declarations, no logic.
package spi_config_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_STATUS    = 8'h05;
  localparam logic [7:0] OP_SET_FLAGS = 8'h20;
  localparam logic [7:0] OP_CLR_FLAGS = 8'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WDATA,
    ST_RDUMMY,
    ST_RDATA,
    ST_MASK,
    ST_STATUS_OUT,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_config_port_spi_byte_shifter.sv
// SPI byte shifter: MSB-first RX with byte_vld on the 8th SS-low edge, TX with parallel load.
// SS high clears both shift registers and the bit counter; no backpressure (the host owns SCLK).
module spi_byte_shifter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ss_i,
  input  logic       mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_data_i,
  output logic       byte_vld_o,
  output logic [7:0] rx_byte_o,
  output logic       miso_o
);

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'd0;
    end else if (ss_i) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'd0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= {rx_q[5:0], mosi_i};
      // A load lands on the edge that completes a byte, so its MSB is on MISO for the next bit.
      tx_q      <= tx_load_i ? tx_data_i : {tx_q[6:0], 1'b0};
    end
  end

  assign byte_vld_o = !ss_i && (bit_cnt_q == 3'd7);
  assign rx_byte_o  = {rx_q, mosi_i};
  assign miso_o     = tx_q[7];

endmodule

// File: rtl/spi_config_port.sv
// SPI slave front-end to a byte-wide config memory and ready flags; writes visible one edge after the last bit.
// Burst read/write with wrapping auto-increment, flag set/clear by mask, status readback; no backpressure.
module spi_config_port
  import spi_config_pkg::*;
#(
  parameter  int MEM_DEPTH = 128,
  parameter  int NUM_FLAGS = 3,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                   SCLK,
  input  logic                   RESET_N,
  input  logic                   SS,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [NUM_FLAGS-1:0]   flags_out,
  output logic [MEM_DEPTH*8-1:0] all_data_out,
  output logic                   wr_pulse,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d, addr_inc, rd_addr;
  logic [7:0]             addr_h_q, addr_h_d;
  logic [7:0]             op_q, op_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic [MEM_DEPTH*8-1:0] mem_q;
  logic                   mem_we;
  logic                   wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   busy_q;
  logic                   tx_load;
  logic [7:0]             tx_data, rd_data;
  logic                   byte_vld;
  logic [7:0]             rx_byte;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(MEM_DEPTH);
  endfunction

  spi_byte_shifter u_shifter (
    .clk_i      (SCLK),
    .rst_ni     (RESET_N),
    .ss_i       (SS),
    .mosi_i     (MOSI),
    .tx_load_i  (tx_load),
    .tx_data_i  (tx_data),
    .byte_vld_o (byte_vld),
    .rx_byte_o  (rx_byte),
    .miso_o     (MISO)
  );

  // Addresses above MEM_DEPTH-1 (non-power-of-two depth) roll over through the natural ADDR_W overflow.
  assign addr_inc = (32'(addr_q) == 32'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign rd_addr  = (state_q == ST_RDATA) ? addr_inc : addr_q;
  assign rd_data  = in_range(rd_addr) ? mem_q[{rd_addr, 3'b000} +: 8] : 8'h00;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_h_d   = addr_h_q;
    op_d       = op_q;
    flags_d    = flags_q;
    mem_we     = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    tx_load    = 1'b0;
    tx_data    = 8'h00;
    if (SS) begin
      state_d = ST_IDLE;
    end else if (byte_vld) begin
      case (state_q)
        ST_IDLE: begin
          op_d = rx_byte;
          case (rx_byte)
            OP_WRITE, OP_READ:         state_d = ST_ADDR_H;
            OP_SET_FLAGS, OP_CLR_FLAGS: state_d = ST_MASK;
            OP_STATUS: begin
              state_d = ST_STATUS_OUT;
              tx_load = 1'b1;
              tx_data = 8'(flags_q);
            end
            default:                   state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR_H: begin
          addr_h_d = rx_byte;
          state_d  = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d  = ADDR_W'({addr_h_q, rx_byte});
          state_d = (op_q == OP_READ) ? ST_RDUMMY : ST_WDATA;
        end
        ST_WDATA: begin
          if (in_range(addr_q)) begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_q;
          end
          addr_d = addr_inc;
        end
        ST_RDUMMY: begin
          tx_load = 1'b1;
          tx_data = rd_data;
          state_d = ST_RDATA;
        end
        ST_RDATA: begin
          addr_d  = addr_inc;
          tx_load = 1'b1;
          tx_data = rd_data;
        end
        ST_MASK: begin
          if (op_q == OP_SET_FLAGS) flags_d = flags_q | rx_byte[NUM_FLAGS-1:0];
          else                      flags_d = flags_q & ~rx_byte[NUM_FLAGS-1:0];
          state_d = ST_IGNORE;
        end
        ST_STATUS_OUT: state_d = ST_IGNORE;
        default:       state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      addr_h_q   <= 8'h00;
      op_q       <= 8'h00;
      flags_q    <= '0;
      mem_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_h_q   <= addr_h_d;
      op_q       <= op_d;
      flags_q    <= flags_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= ~SS;
      if (mem_we) mem_q[{addr_q, 3'b000} +: 8] <= rx_byte;
    end
  end

  assign flags_out    = flags_q;
  assign all_data_out = mem_q;
  assign wr_pulse     = wr_pulse_q;
  assign wr_addr      = wr_addr_q;
  assign busy         = busy_q;

endmodule

// File: doc/spi_config_port.md
Name: spi_config_port

Overview:
Parametrised successor to the team's SPI configuration front-end. It is an SPI slave (mode: MOSI sampled on SCLK rising edge, MSB first) feeding a byte-wide configuration memory of MEM_DEPTH words and a bank of NUM_FLAGS ready flags. It adds:
- burst read/write with address auto-increment;
- 16-bit addressing;
- flag set/clear by mask;
- status readback.

It sits between the external host and the SNN core, which consumes all_data_out and flags_out.

Parameters:
MEM_DEPTH, 128, number of 8-bit config words; any value 2..65536, not necessarily a power of two.
ADDR_W, $clog2(MEM_DEPTH), internal address width; derived, not overridden.
NUM_FLAGS, 3, number of ready flags; 1..8 (bit0 clk_div_ready, bit1 input_spike_ready, bit2 debug_config_ready).

Ports:
SCLK  in  1  SPI clock, the only clock; all state on rising edge.
RESET_N  in  1  asynchronous, active-low reset.
SS  in  1  active-low chip select, sampled on SCLK rising edge.
MOSI  in  1  serial data in.
MISO  out  1  serial data out, MSB first.
flags_out  out  NUM_FLAGS  ready flag register.
all_data_out  out  MEM_DEPTH*8  flattened memory; word i at [8i+7:8i].
wr_pulse  out  1  one-cycle strobe on each committed memory write.
wr_addr  out  ADDR_W  address of the last committed write.
busy  out  1  high while a frame is in progress (SS sampled low).

Behaviour:
Reset (RESET_N low, asynchronous):
- memory all 0x00; flags_out 0; MISO 0; wr_pulse 0; wr_addr 0; busy 0;
- FSM to IDLE; bit counter 0.

Framing:
- SS sampled high at any rising edge: bit counter cleared, FSM to IDLE, partial byte discarded, MISO 0.
- The host guarantees at least one SCLK edge with SS high between frames.
- A byte completes on the 8th rising edge with SS low.
- The FSM advances on byte completion only.

Opcodes:
- 0x02 WRITE
- 0x03 READ
- 0x05 STATUS
- 0x20 SET_FLAGS
- 0x21 CLR_FLAGS

FSM states: IDLE, ADDR_H, ADDR_L, WDATA, RDUMMY, RDATA, MASK, STATUS_OUT, IGNORE.
- IDLE, byte = opcode:
  - WRITE or READ → ADDR_H.
  - SET_FLAGS or CLR_FLAGS → MASK.
  - STATUS → STATUS_OUT.
  - any other value → IGNORE until SS high.
- ADDR_H → ADDR_L. Address = {ADDR_H, ADDR_L}[ADDR_W-1:0]; upper bits beyond ADDR_W are ignored.
- ADDR_L:
  - WRITE → WDATA.
  - READ → RDUMMY.
- WDATA, per byte:
  - if addr < MEM_DEPTH: mem[addr] <= byte; wr_pulse high on the same edge's next cycle for exactly 1 cycle; wr_addr <= addr.
  - else: byte dropped, no pulse.
  - addr <= (addr == MEM_DEPTH-1) ? 0 : addr+1.
  - Stays in WDATA until SS high.
- RDUMMY:
  - One dummy byte clocked in (value ignored); MISO 0.
  - On its completion, tx shift register loads mem[addr], or 0x00 if out of range → RDATA.
- RDATA:
  - MISO shifts the loaded byte, MSB first, one bit per rising edge.
  - At byte completion: addr increments with the same wrap rule, and the next word is loaded.
  - Unbounded burst until SS high.
- MASK, byte m:
  - SET: flags <= flags | m[NUM_FLAGS-1:0].
  - CLR: flags <= flags & ~m[NUM_FLAGS-1:0].
  - Then → IGNORE.
- STATUS_OUT:
  - After the opcode byte, MISO shifts {zero-pad, flags_out} (8 bits).
  - Further bytes return 0x00 (state → IGNORE).
- IGNORE: consumes bytes, MISO 0, no state changes.

MISO timing:
- Updated on rising edge; bit 7 of a loaded byte is valid after the edge that completes the previous byte.
- MISO is 0 whenever no read or status data is active.

Latency:
- Written word visible on all_data_out 1 cycle after the 8th data bit edge.

Simultaneous events:
- Memory writes and flag updates never coincide (they belong to distinct opcodes).
- An address wrap within a read or write burst is seamless.

Reset mid-frame:
- Full reset. Memory contents are lost; this is intended.

Decomposition:
Package spi_config_pkg holds:
- opcode localparams: OP_WRITE, OP_READ, OP_STATUS, OP_SET_FLAGS, OP_CLR_FLAGS;
- FSM state encoding.

One sub-module: spi_byte_shifter, which contains:
- RX shift register + bit counter + byte_valid;
- TX shift register with a load port;
- SS-high clear.

The FSM, address counter, flags and memory array live in spi_config_port.

Test Plan:
1. Reset, then write burst: frame 02 00 10 AA BB CC → all_data_out words 16/17/18 = AA/BB/CC; wr_pulse three single-cycle pulses; wr_addr ends 18.
2. Read burst: frame 03 00 10 00 xx xx xx → MISO bytes AA BB CC during bytes 4-6.
3. Wrap: write 02 00 7F 11 22 with MEM_DEPTH=128 → word127=11, word0=22.
4. Out of range, with MEM_DEPTH=100:
   - write 02 00 64 55 → no wr_pulse, memory unchanged;
   - read at 0x64 → MISO 0x00.
5. Flags:
   - 20 05 → flags 3'b101;
   - 21 01 → 3'b100;
   - 05 xx → MISO byte 0x04.
6. Abort and reset:
   - 0x0F opcode → ignored, no writes;
   - SS high after 4 bits of a data byte → byte discarded, next frame decodes correctly;
   - RESET_N low mid-burst → memory, flags, MISO all 0 immediately.
